// File: rtl/tdm_demux12.sv
// tdm_demux12: receiving end of a 2:1 time-division link.
// Locks onto the SYNC-marked slot 0 beat, pairs it with the following
// slot 1 beat, and presents each completed frame as two registered words.
// Optional build macro: TDM_DEMUX_PARITY_EN adds input P (even parity over D);
// a beat with bad parity raises ERR, is dropped and forces the receiver to HUNT.
module tdm_demux12 #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          VALID_IN,
    input  logic          SYNC,
    input  logic [W-1:0]  D,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic          P,
`endif
    output logic [W-1:0]  Y0,
    output logic [W-1:0]  Y1,
    output logic          VALID_OUT,
    output logic          S1,
    output logic          LOCKED,
    output logic          ERR,
    output logic [CW-1:0] FCNT
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        EXP0 = 2'd1,
        EXP1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    hold_q,  hold_d;
    logic [W-1:0]    y0_q,    y0_d;
    logic [W-1:0]    y1_q,    y1_d;
    logic            valid_out_q, valid_out_d;
    logic            err_q,   err_d;
    logic [CW-1:0]   fcnt_q,  fcnt_d;
    logic            parity_ok;

`ifdef TDM_DEMUX_PARITY_EN
    assign parity_ok = (P == ^D);
`else
    assign parity_ok = 1'b1;
`endif

    // Next-state and datapath: only beats with VALID_IN=1 advance anything.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        fcnt_d      = fcnt_q;
        valid_out_d = 1'b0;
        err_d       = 1'b0;
        if (VALID_IN) begin
            if (!parity_ok) begin
                err_d   = 1'b1;
                state_d = HUNT;
            end else begin
                case (state_q)
                    HUNT: begin
                        if (SYNC) begin
                            hold_d  = D;
                            state_d = EXP1;
                        end
                    end
                    EXP1: begin
                        if (SYNC) begin
                            err_d  = 1'b1;
                            hold_d = D;
                        end else begin
                            y0_d        = hold_q;
                            y1_d        = D;
                            valid_out_d = 1'b1;
                            fcnt_d      = fcnt_q + CW'(1);
                            state_d     = EXP0;
                        end
                    end
                    EXP0: begin
                        if (SYNC) begin
                            hold_d  = D;
                            state_d = EXP1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = HUNT;
                        end
                    end
                    default: begin
                        state_d = HUNT;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= HUNT;
            hold_q      <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            valid_out_q <= 1'b0;
            err_q       <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            valid_out_q <= valid_out_d;
            err_q       <= err_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign Y0        = y0_q;
    assign Y1        = y1_q;
    assign VALID_OUT = valid_out_q;
    assign ERR       = err_q;
    assign FCNT      = fcnt_q;
    assign S1        = (state_q == EXP1);
    assign LOCKED    = (state_q == EXP0) || (state_q == EXP1);

endmodule

// File: tb/tb_tdm_demux12.sv
// Testbench for tdm_demux12: table vectors, hand-written corner sequences
// and randomized beats compared against a frame-level reference model.
module tb_tdm_demux12;

    localparam int W  = 4;
    localparam int CW = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          VALID_IN = 1'b0;
    logic          SYNC = 1'b0;
    logic [W-1:0]  D = '0;
`ifdef TDM_DEMUX_PARITY_EN
    logic          P = 1'b0;
`endif
    logic [W-1:0]  Y0, Y1;
    logic          VALID_OUT, S1, LOCKED, ERR;
    logic [CW-1:0] FCNT;

    int checks = 0;
    int errors = 0;

    // Reference model: expected slot (-1 = hunting), pending slot 0 word,
    // last delivered frame and pulse flags after the most recent clock.
    int          mExp;
    logic [W-1:0] mHold, mY0, mY1;
    bit          mVo, mErr;
    int          mFcnt;

    tdm_demux12 #(.W(W), .CW(CW)) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .VALID_IN(VALID_IN),
        .SYNC(SYNC),
        .D(D),
`ifdef TDM_DEMUX_PARITY_EN
        .P(P),
`endif
        .Y0(Y0),
        .Y1(Y1),
        .VALID_OUT(VALID_OUT),
        .S1(S1),
        .LOCKED(LOCKED),
        .ERR(ERR),
        .FCNT(FCNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit           v;
        bit           s;
        logic [W-1:0] d;
        logic [W-1:0] y0;
        logic [W-1:0] y1;
        bit           vo;
        bit           err;
        bit           lk;
        bit           s1;
        logic [CW-1:0] fc;
    } vec_t;

    vec_t tbl[10];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mExp  = -1;
        mHold = '0;
        mY0   = '0;
        mY1   = '0;
        mVo   = 1'b0;
        mErr  = 1'b0;
        mFcnt = 0;
    endtask

    // One beat of the frame-level model: a SYNC beat always starts a new
    // frame (complaining if the previous one was only half received), a
    // non-SYNC beat either finishes a frame, breaks alignment, or is dropped.
    task automatic modelBeat(input bit v, input bit s, input logic [W-1:0] d, input bit badPar);
        mVo  = 1'b0;
        mErr = 1'b0;
        if (!v) return;
        if (PAR_EN && badPar) begin
            mErr = 1'b1;
            mExp = -1;
        end else if (s) begin
            mErr  = (mExp == 1);
            mHold = d;
            mExp  = 1;
        end else if (mExp == 1) begin
            mY0   = mHold;
            mY1   = d;
            mVo   = 1'b1;
            mFcnt = (mFcnt + 1) % (1 << CW);
            mExp  = 0;
        end else if (mExp == 0) begin
            mErr = 1'b1;
            mExp = -1;
        end
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, ".Y0"},     32'(Y0),        32'(mY0));
        cmp({tag, ".Y1"},     32'(Y1),        32'(mY1));
        cmp({tag, ".VALID"},  32'(VALID_OUT), 32'(mVo));
        cmp({tag, ".ERR"},    32'(ERR),       32'(mErr));
        cmp({tag, ".S1"},     32'(S1),        32'(mExp == 1));
        cmp({tag, ".LOCKED"}, 32'(LOCKED),    32'(mExp != -1));
        cmp({tag, ".FCNT"},   32'(FCNT),      32'(mFcnt));
    endtask

    // Drives one cycle of link inputs, clocks it, and checks against the model.
    task automatic applyStimulus(input bit v, input bit s, input logic [W-1:0] d,
                                 input bit badPar, input string tag);
        VALID_IN = v;
        SYNC     = s;
        D        = d;
`ifdef TDM_DEMUX_PARITY_EN
        P = (^d) ^ badPar;
`endif
        @(posedge CLK);
        modelBeat(v, s, d, badPar);
        #1;
        checkOutput(tag);
    endtask

    task automatic doReset();
        #1;
        RSTN = 1'b0;
        VALID_IN = 1'b0;
        #2;
        modelReset();
        checkOutput("async_reset");
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
    endtask

    initial begin
        modelReset();
        tbl[0] = '{1, 1, 4'hA, 4'h0, 4'h0, 0, 0, 1, 1, 8'd0};
        tbl[1] = '{1, 0, 4'h5, 4'hA, 4'h5, 1, 0, 1, 0, 8'd1};
        tbl[2] = '{0, 0, 4'hF, 4'hA, 4'h5, 0, 0, 1, 0, 8'd1};
        tbl[3] = '{1, 0, 4'h7, 4'hA, 4'h5, 0, 1, 0, 0, 8'd1};
        tbl[4] = '{1, 0, 4'h8, 4'hA, 4'h5, 0, 0, 0, 0, 8'd1};
        tbl[5] = '{1, 1, 4'h1, 4'hA, 4'h5, 0, 0, 1, 1, 8'd1};
        tbl[6] = '{1, 0, 4'h2, 4'h1, 4'h2, 1, 0, 1, 0, 8'd2};
        tbl[7] = '{1, 1, 4'h4, 4'h1, 4'h2, 0, 0, 1, 1, 8'd2};
        tbl[8] = '{1, 1, 4'h6, 4'h1, 4'h2, 0, 1, 1, 1, 8'd2};
        tbl[9] = '{1, 0, 4'h9, 4'h6, 4'h9, 1, 0, 1, 0, 8'd3};

        #3;
        checkOutput("power_on_reset");
        @(posedge CLK);
        #1;
        RSTN = 1'b1;

        // Idle after reset: nothing moves, receiver stays unlocked.
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 4'h0, 0, "idle");

        // Table vectors: normal frame, slot-0 slip, hunting, premature SYNC.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].v, tbl[i].s, tbl[i].d, 0, $sformatf("tbl%0d", i));
            cmp($sformatf("tbl%0d.Y0c", i),  32'(Y0),        32'(tbl[i].y0));
            cmp($sformatf("tbl%0d.Y1c", i),  32'(Y1),        32'(tbl[i].y1));
            cmp($sformatf("tbl%0d.VOc", i),  32'(VALID_OUT), 32'(tbl[i].vo));
            cmp($sformatf("tbl%0d.ERRc", i), 32'(ERR),       32'(tbl[i].err));
            cmp($sformatf("tbl%0d.LKc", i),  32'(LOCKED),    32'(tbl[i].lk));
            cmp($sformatf("tbl%0d.S1c", i),  32'(S1),        32'(tbl[i].s1));
            cmp($sformatf("tbl%0d.FCc", i),  32'(FCNT),      32'(tbl[i].fc));
        end

        // Gapped frame: slot 1 expected throughout the idle gap.
        applyStimulus(1, 1, 4'h3, 0, "gap_s0");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 4'h0, 0, "gap_idle");
            cmp("gap_S1_const", 32'(S1), 32'd1);
            cmp("gap_VO_const", 32'(VALID_OUT), 32'd0);
        end
        applyStimulus(1, 0, 4'hC, 0, "gap_s1");
        cmp("gap_Y0_const", 32'(Y0), 32'h3);
        cmp("gap_Y1_const", 32'(Y1), 32'hC);
        cmp("gap_VO1_const", 32'(VALID_OUT), 32'd1);
        applyStimulus(0, 0, 4'h0, 0, "gap_after");
        cmp("gap_VO_single", 32'(VALID_OUT), 32'd0);

`ifdef TDM_DEMUX_PARITY_EN
        // Bad parity on a slot 1 beat never completes the frame.
        applyStimulus(1, 1, 4'hB, 0, "par_s0");
        applyStimulus(1, 0, 4'hD, 1, "par_s1_bad");
        cmp("par_ERR_const", 32'(ERR), 32'd1);
        cmp("par_VO_const", 32'(VALID_OUT), 32'd0);
        cmp("par_LK_const", 32'(LOCKED), 32'd0);
        cmp("par_Y1_const", 32'(Y1), 32'hC);
`endif

        // Counter wrap: 256 back-to-back frames from reset.
        doReset();
        for (int f = 0; f < 256; f++) begin
            applyStimulus(1, 1, 4'(f), 0, "wrap_s0");
            applyStimulus(1, 0, 4'(f + 1), 0, "wrap_s1");
            if (f == 254) cmp("wrap_255_const", 32'(FCNT), 32'd255);
        end
        cmp("wrap_zero_const", 32'(FCNT), 32'd0);
        cmp("wrap_vo_const", 32'(VALID_OUT), 32'd1);

        // Randomized beats, with an asynchronous reset dropped in mid-run.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) doReset();
            applyStimulus(($urandom_range(3) != 0), $urandom_range(1) == 1,
                          W'($urandom), ($urandom_range(9) == 0), "rand");
            if (ERR && VALID_OUT) begin
                checks++;
                errors++;
                $display("[TB] FAIL rand_exclusive: ERR=%0b VALID_OUT=%0b both set", ERR, VALID_OUT);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
